// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid.
// Ports: clk, rst (async high), flush_i, cnt_clr_i, in_* (upstream),
//        out_* (downstream), occupancy_o, stall_cnt_o.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              cnt_clr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_d, skid_d;
   logic              main_v_n, skid_v_n;
   logic [DATA_W-1:0] main_d_n, skid_d_n;
   logic              accept, consume;
   logic [CNT_W-1:0]  cnt;

   // ready only looks at the skid register, keeping out_ready_i off
   // the upstream ready path
   assign in_ready_o = !skid_v;
   assign accept     = in_valid_i && !skid_v;
   assign consume    = main_v && out_ready_i;

   always_comb begin
      main_v_n = main_v;
      main_d_n = main_d;
      skid_v_n = skid_v;
      skid_d_n = skid_d;
      unique case (1'b1)
         flush_i: begin
            main_v_n = 1'b0;
            main_d_n = '0;
            skid_v_n = 1'b0;
            skid_d_n = '0;
         end
         (!flush_i && !main_v): begin
            if (accept) begin
               main_v_n = 1'b1;
               main_d_n = in_data_i;
            end
         end
         (!flush_i && consume && skid_v): begin
            main_d_n = skid_d;
            skid_v_n = 1'b0;
            skid_d_n = '0;
         end
         (!flush_i && consume && !skid_v): begin
            if (accept) begin
               main_d_n = in_data_i;
            end else begin
               main_v_n = 1'b0;
               main_d_n = '0;
            end
         end
         (!flush_i && main_v && !out_ready_i): begin
            if (accept) begin
               skid_v_n = 1'b1;
               skid_d_n = in_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_v <= 1'b0;
         main_d <= '0;
         skid_v <= 1'b0;
         skid_d <= '0;
      end else begin
         main_v <= main_v_n;
         main_d <= main_d_n;
         skid_v <= skid_v_n;
         skid_d <= skid_d_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt_clr_i) begin
         cnt <= '0;
      end else if (main_v && !out_ready_i && cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign out_valid_o = main_v;
   assign out_data_o  = main_d;
   assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};
   assign stall_cnt_o = cnt;

endmodule
